btn_debouncer: RTL

Four-channel push-button conditioner that sits directly upstream of the smart responder (quiz buzzer) on the board. Raw, asynchronous, bouncing key inputs are synchronised to `clk` and filtered by a per-channel stability counter. The block then presents clean levels, which drive the responder's `btn[3:0]`, plus single-cycle press and release pulses for any logic that needs edges. All four channels are identical and fully independent.

---
 rtl/btn_debouncer_if.sv | 27 ++
 rtl/btn_debouncer.sv | 66 ++++++
 2 files changed

// File: rtl/btn_debouncer_if.sv
// Button conditioner signal bundle: raw keys in, debounced levels and edge pulses out.
`timescale 1ns/1ps
interface btn_debouncer_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0] btn_raw;
  logic [WIDTH-1:0] btn_level;
  logic [WIDTH-1:0] btn_press;
  logic [WIDTH-1:0] btn_release;
  logic             any_press;

  modport master (
    output btn_raw,
    input  btn_level,
    input  btn_press,
    input  btn_release,
    input  any_press
  );

  modport slave (
    input  btn_raw,
    output btn_level,
    output btn_press,
    output btn_release,
    output any_press
  );
endinterface

// File: rtl/btn_debouncer.sv
// Per-channel push-button conditioner: two-flop synchroniser, stability counter,
// debounced level and single-cycle press/release pulses.
`timescale 1ns/1ps
module btn_debouncer #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 2_000_000
) (
  input  logic            clk,
  input  logic            rst_n,
  btn_debouncer_if.slave  bus
);

  localparam int             CNT_W   = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] sync_p0;
  logic [WIDTH-1:0] sync_p1;
  logic [CNT_W-1:0] cnt_p2 [WIDTH];
  logic [WIDTH-1:0] level_p2;
  logic [WIDTH-1:0] press_p2;
  logic [WIDTH-1:0] release_p2;

  // Stage p0/p1: metastability synchroniser; only sync_p1 is used downstream
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
    end else begin
      sync_p0 <= bus.btn_raw;
      sync_p1 <= sync_p0;
    end
  end

  // Stage p2: stability counter; any return to the current level restarts the count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < WIDTH; i++) begin
        cnt_p2[i] <= '0;
      end
      level_p2   <= '0;
      press_p2   <= '0;
      release_p2 <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        press_p2[i]   <= 1'b0;
        release_p2[i] <= 1'b0;
        if (sync_p1[i] == level_p2[i]) begin
          cnt_p2[i] <= '0;
        end else if (cnt_p2[i] == CNT_MAX) begin
          level_p2[i]   <= sync_p1[i];
          press_p2[i]   <= sync_p1[i];
          release_p2[i] <= ~sync_p1[i];
          cnt_p2[i]     <= '0;
        end else begin
          cnt_p2[i] <= cnt_p2[i] + 1'b1;
        end
      end
    end
  end

  assign bus.btn_level   = level_p2;
  assign bus.btn_press   = press_p2;
  assign bus.btn_release = release_p2;
  assign bus.any_press   = |press_p2;

endmodule
